// File: rtl/instr_encoder.sv
// RV32I field packer: accepts one field bundle, encodes it, and writes it to
// instruction memory at an auto-incrementing word address (IDLE -> ENCODE -> WRITE).
module instr_encoder #(
  parameter int          ADDR_WIDTH = 10,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_type,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [12:0]           in_imm,
  output logic                  mem_wr_en,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [15:0]           wr_count,
  output logic                  err_illegal,
  output logic                  err_align,
  output logic                  wrapped
);

  localparam logic [ADDR_WIDTH-1:0] LP_BASE = BASE_ADDR[ADDR_WIDTH-1:0];

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENCODE = 2'd1,
    S_WRITE  = 2'd2
  } state_t;

  state_t                r_state;
  logic [2:0]            r_type;
  logic [4:0]            r_rd;
  logic [4:0]            r_rs1;
  logic [4:0]            r_rs2;
  logic [2:0]            r_f3;
  logic [6:0]            r_f7;
  logic [12:0]           r_imm;
  logic                  r_wr_en;
  logic [31:0]           r_wdata;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [15:0]           r_count;
  logic                  r_err_ill;
  logic                  r_err_align;
  logic                  r_wrapped;

  logic [31:0]           w_word;
  logic                  w_legal;

  // BRANCH drops imm[0]; it only feeds the alignment flag.
  always_comb begin
    w_legal = 1'b1;
    w_word  = '0;
    case (r_type)
      3'd0: w_word = {r_f7, r_rs2, r_rs1, r_f3, r_rd, 7'b0110011};
      3'd1: w_word = {r_imm[11:0], r_rs1, r_f3, r_rd, 7'b0010011};
      3'd2: w_word = {r_imm[11:0], r_rs1, r_f3, r_rd, 7'b0000011};
      3'd3: w_word = {r_imm[11:5], r_rs2, r_rs1, r_f3, r_imm[4:0], 7'b0100011};
      3'd4: w_word = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, r_f3,
                      r_imm[4:1], r_imm[11], 7'b1100011};
      default: w_legal = 1'b0;
    endcase
  end

  assign in_ready    = (r_state == S_IDLE) && !reset && !clear;
  assign mem_wr_en   = r_wr_en;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign wr_count    = r_count;
  assign err_illegal = r_err_ill;
  assign err_align   = r_err_align;
  assign wrapped     = r_wrapped;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_type      <= '0;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_f3        <= '0;
      r_f7        <= '0;
      r_imm       <= '0;
      r_wr_en     <= 1'b0;
      r_wdata     <= '0;
      r_addr      <= LP_BASE;
      r_count     <= '0;
      r_err_ill   <= 1'b0;
      r_err_align <= 1'b0;
      r_wrapped   <= 1'b0;
    end else if (clear) begin
      r_state     <= S_IDLE;
      r_wr_en     <= 1'b0;
      r_addr      <= LP_BASE;
      r_count     <= '0;
      r_err_ill   <= 1'b0;
      r_err_align <= 1'b0;
      r_wrapped   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_type  <= in_type;
            r_rd    <= in_rd;
            r_rs1   <= in_rs1;
            r_rs2   <= in_rs2;
            r_f3    <= in_funct3;
            r_f7    <= in_funct7;
            r_imm   <= in_imm;
            r_state <= S_ENCODE;
          end
        end
        S_ENCODE: begin
          if (w_legal) begin
            r_wdata <= w_word;
            r_wr_en <= 1'b1;
            r_state <= S_WRITE;
            if (r_type == 3'd4 && r_imm[0]) r_err_align <= 1'b1;
          end else begin
            r_err_ill <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        S_WRITE: begin
          if (mem_ready) begin
            r_wr_en <= 1'b0;
            r_addr  <= r_addr + ADDR_WIDTH'(1);
            if (&r_addr) r_wrapped <= 1'b1;
            if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: known-vector table, stall/reset/clear sequences, and
// randomized bundles checked against an arithmetic encoding/scoreboard model.
module tb_instr_encoder;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset, clear, in_valid, in_ready, mem_wr_en, mem_ready;
  logic [2:0]    in_type, in_funct3;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [6:0]    in_funct7;
  logic [12:0]   in_imm;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [15:0]   wr_count;
  logic          err_illegal, err_align, wrapped;

  instr_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .mem_wr_en(mem_wr_en), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .wr_count(wr_count), .err_illegal(err_illegal),
    .err_align(err_align), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          t, rd, rs1, rs2, f3, f7, imm, stall;
    logic [31:0] exp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard state
  int m_addr = 0, m_count = 0;
  bit m_ill = 0, m_align = 0, m_wrap = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_enc(input vec_t v);
    longint w;
    longint imm;
    imm = v.imm;
    w = 0;
    case (v.t)
      0: w = v.f7 * (2**25) + v.rs2 * (2**20) + v.rs1 * (2**15) + v.f3 * (2**12) + v.rd * (2**7) + 51;
      1: w = (imm % 4096) * (2**20) + v.rs1 * (2**15) + v.f3 * (2**12) + v.rd * (2**7) + 19;
      2: w = (imm % 4096) * (2**20) + v.rs1 * (2**15) + v.f3 * (2**12) + v.rd * (2**7) + 3;
      3: w = ((imm / 32) % 128) * (2**25) + v.rs2 * (2**20) + v.rs1 * (2**15) + v.f3 * (2**12)
             + (imm % 32) * (2**7) + 35;
      4: w = ((imm / 4096) % 2) * (64'd1 << 31) + ((imm / 32) % 64) * (2**25) + v.rs2 * (2**20)
             + v.rs1 * (2**15) + v.f3 * (2**12) + ((imm / 2) % 16) * (2**8)
             + ((imm / 2048) % 2) * (2**7) + 99;
      default: w = 0;
    endcase
    return w[31:0];
  endfunction

  task automatic check_flags(input string tag);
    chk({tag, " addr"},   32'(mem_addr), 32'(m_addr));
    chk({tag, " count"},  32'(wr_count), 32'(m_count));
    chk({tag, " ill"},    32'(err_illegal), 32'(m_ill));
    chk({tag, " align"},  32'(err_align), 32'(m_align));
    chk({tag, " wrap"},   32'(wrapped), 32'(m_wrap));
  endtask

  task automatic send(input vec_t v, input string tag);
    int guard;
    @(negedge clk);
    in_type = v.t[2:0]; in_rd = v.rd[4:0]; in_rs1 = v.rs1[4:0]; in_rs2 = v.rs2[4:0];
    in_funct3 = v.f3[2:0]; in_funct7 = v.f7[6:0]; in_imm = v.imm[12:0];
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL %s accept timeout: in_ready=0 after 20 cycles, required 1", tag);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic do_txn(input vec_t v, input string tag);
    send(v, tag);
    @(negedge clk);
    chk({tag, " encode wr_en"}, 32'(mem_wr_en), 0);
    if (v.t > 4) begin
      m_ill = 1;
      @(negedge clk);
      chk({tag, " illegal wr_en"}, 32'(mem_wr_en), 0);
      chk({tag, " illegal rdy"}, 32'(in_ready), 1);
      check_flags(tag);
      return;
    end
    @(negedge clk);
    chk({tag, " wr_en"}, 32'(mem_wr_en), 1);
    chk({tag, " addr"}, 32'(mem_addr), 32'(m_addr));
    chk({tag, " wdata"}, mem_wdata, v.exp);
    chk({tag, " busy rdy"}, 32'(in_ready), 0);
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk);
      chk({tag, " stall wr_en"}, 32'(mem_wr_en), 1);
      chk({tag, " stall addr"}, 32'(mem_addr), 32'(m_addr));
      chk({tag, " stall wdata"}, mem_wdata, v.exp);
      chk({tag, " stall rdy"}, 32'(in_ready), 0);
    end
    mem_ready = 1'b1;
    @(posedge clk);
    #1 mem_ready = 1'b0;
    if (m_addr == (1 << AW) - 1) m_wrap = 1;
    m_addr = (m_addr + 1) % (1 << AW);
    if (m_count < 65535) m_count++;
    if (v.t == 4 && v.imm % 2 == 1) m_align = 1;
    @(negedge clk);
    chk({tag, " post wr_en"}, 32'(mem_wr_en), 0);
    chk({tag, " post rdy"}, 32'(in_ready), 1);
    chk({tag, " held wdata"}, mem_wdata, v.exp);
    check_flags(tag);
  endtask

  task automatic model_reset();
    m_addr = 0; m_count = 0; m_ill = 0; m_align = 0; m_wrap = 0;
  endtask

  vec_t tbl[7];
  vec_t v;

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
    in_type = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;

    tbl[0] = '{0, 3, 1, 2, 0, 0, 0,      0, 32'h002081B3};
    tbl[1] = '{1, 5, 0, 0, 0, 0, 'h1FFF, 0, 32'hFFF00293};
    tbl[2] = '{3, 0, 1, 2, 2, 0, 8,      5, 32'h0020A423};
    tbl[3] = '{4, 0, 1, 2, 0, 0, 'h1FFC, 1, 32'hFE208EE3};
    tbl[4] = '{4, 0, 1, 2, 0, 0, 'h1FFD, 0, 32'hFE208EE3};
    tbl[5] = '{5, 7, 7, 7, 7, 7, 7,      0, 32'h0};
    tbl[6] = '{2, 4, 1, 0, 2, 0, 12,     2, 32'h00C0A203};

    repeat (2) @(negedge clk);
    chk("rst rdy", 32'(in_ready), 0);
    chk("rst wr_en", 32'(mem_wr_en), 0);
    chk("rst wdata", mem_wdata, 0);
    check_flags("rst");
    reset = 1'b0;
    @(negedge clk);
    chk("idle rdy", 32'(in_ready), 1);

    for (int i = 0; i < 7; i++) do_txn(tbl[i], $sformatf("vec%0d", i));

    // reset while a write is pending
    send(tbl[0], "rstwr");
    repeat (2) @(negedge clk);
    chk("rstwr pending", 32'(mem_wr_en), 1);
    reset = 1'b1;
    #1;
    chk("rstwr wr_en", 32'(mem_wr_en), 0);
    chk("rstwr rdy", 32'(in_ready), 0);
    model_reset();
    check_flags("rstwr");
    @(negedge clk);
    reset = 1'b0;

    // clear while a write is pending drops it and zeroes counters
    do_txn(tbl[1], "pre_clr");
    send(tbl[5], "pre_clr_ill");
    repeat (2) @(negedge clk);
    send(tbl[0], "clrwr");
    repeat (2) @(negedge clk);
    clear = 1'b1;
    #1 chk("clrwr rdy", 32'(in_ready), 0);
    @(negedge clk);
    clear = 1'b0;
    model_reset();
    chk("clrwr wr_en", 32'(mem_wr_en), 0);
    check_flags("clrwr");

    // clear beats a simultaneous in_valid
    in_type = 3'd0; in_valid = 1'b1; clear = 1'b1;
    #1 chk("clrv rdy", 32'(in_ready), 0);
    @(negedge clk);
    in_valid = 1'b0; clear = 1'b0;
    repeat (2) @(negedge clk);
    chk("clrv wr_en", 32'(mem_wr_en), 0);
    chk("clrv idle rdy", 32'(in_ready), 1);
    check_flags("clrv");

    for (int i = 0; i < 40; i++) begin
      v.t = int'($urandom_range(7)); v.rd = int'($urandom_range(31));
      v.rs1 = int'($urandom_range(31)); v.rs2 = int'($urandom_range(31));
      v.f3 = int'($urandom_range(7)); v.f7 = int'($urandom_range(127));
      v.imm = int'($urandom_range(8191)); v.stall = int'($urandom_range(3));
      v.exp = model_enc(v);
      do_txn(v, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
